// File: rtl/fetch_if_id_pkg.sv
// Shared pipeline constants: PC width, NOP encoding, reset vector and fetch FSM encoding.
package fetch_if_id_pkg;
  localparam int PC_W = 32;
  localparam logic [PC_W-1:0] NOP_INSTR    = 32'h0000_0000;
  localparam logic [PC_W-1:0] RESET_PC_DEF = 32'h0000_0000;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } fetch_state_t;
endpackage

// File: rtl/fetch_if_id_stat_counter.sv
// Wrapping statistics counter; synchronous active-low clear wins over enable.
// Single-cycle update, no backpressure.
module stat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             en,
  output logic [CNT_W-1:0] cnt
);
  always_ff @(posedge clk) begin
    if (!clr_n) cnt <= '0;
    else if (en) cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/fetch_if_id.sv
// Fetch stage + IF/ID register: instruction at PC appears on IR_o one cycle later.
// Stall holds PC and IF/ID; redirect flushes and overrides stall/halt.
module fetch_if_id
  import fetch_if_id_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEF,
  parameter logic [PC_W-1:0] NOP      = NOP_INSTR,
  parameter int              CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_i,
  input  logic             jump_rst,
  input  logic [PC_W-1:0]  jump_pc_i,
  input  logic             halt_i,
  input  logic             go_i,
  output logic [PC_W-1:0]  imem_addr_o,
  input  logic [PC_W-1:0]  imem_data_i,
  output logic [PC_W-1:0]  IR_o,
  output logic [PC_W-1:0]  PC_o,
  output logic             valid_o,
  output logic             halted_o,
  output logic [CNT_W-1:0] cycle_cnt_o,
  output logic [CNT_W-1:0] instr_cnt_o,
  output logic [CNT_W-1:0] jump_cnt_o,
  output logic [CNT_W-1:0] stall_cnt_o
);
  fetch_state_t    state, state_n;
  logic [PC_W-1:0] pc, pc_n, ir_n, pc_o_n;
  logic            valid_n;
  logic            run;
  logic [PC_W-1:0] pc_inc;

  assign run         = (state == ST_RUN);
  assign pc_inc      = pc + 32'd1;
  assign imem_addr_o = pc;
  assign halted_o    = (state == ST_HALT);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= ST_RUN;
      pc      <= RESET_PC;
      IR_o    <= NOP;
      PC_o    <= '0;
      valid_o <= 1'b0;
    end else begin
      state   <= state_n;
      pc      <= pc_n;
      IR_o    <= ir_n;
      PC_o    <= pc_o_n;
      valid_o <= valid_n;
    end
  end

  always_comb begin
    state_n = state;
    pc_n    = pc;
    ir_n    = IR_o;
    pc_o_n  = PC_o;
    valid_n = valid_o;
    // Redirect beats everything in both states: the IF/ID word is wrong-path.
    if (jump_rst) begin
      state_n = ST_RUN;
      pc_n    = jump_pc_i;
      ir_n    = NOP;
      pc_o_n  = '0;
      valid_n = 1'b0;
    end else if (run) begin
      if (halt_i && valid_o && !stall_i) begin
        state_n = ST_HALT;
        ir_n    = NOP;
        valid_n = 1'b0;
      end else if (!stall_i) begin
        pc_n    = pc_inc;
        ir_n    = imem_data_i;
        pc_o_n  = pc_inc;
        valid_n = 1'b1;
      end
    end else if (go_i) begin
      state_n = ST_RUN;
    end
  end

  stat_counter #(.CNT_W(CNT_W)) u_cycle_cnt (
    .clk(clk), .clr_n(rst), .en(run), .cnt(cycle_cnt_o));
  stat_counter #(.CNT_W(CNT_W)) u_instr_cnt (
    .clk(clk), .clr_n(rst), .en(run && valid_o && !stall_i && !jump_rst), .cnt(instr_cnt_o));
  stat_counter #(.CNT_W(CNT_W)) u_jump_cnt (
    .clk(clk), .clr_n(rst), .en(jump_rst), .cnt(jump_cnt_o));
  stat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk(clk), .clr_n(rst), .en(run && stall_i && !jump_rst), .cnt(stall_cnt_o));
endmodule

// File: doc/fetch_if_id.md
Name: fetch_if_id

Overview:
- Fetch stage plus IF/ID pipeline register of the 5-stage word-addressed MIPS-subset pipeline. Sits directly upstream of id_ex.
- Owns the PC. Drives the instruction-memory address and latches instruction and PC+1 into IF/ID.
- Honours the load-use stall (the same event that drives bubble_rst into id_ex), the EX-stage redirect (jump_rst), and the decode-stage halt.
- Also keeps the run-statistics counters shown on the board display.

Parameters:
- RESET_PC, 32'h0000_0000, word address fetched first after reset.
- NOP, 32'h0000_0000, encoding inserted into IF/ID on flush/halt.
- CNT_W, 32, width of every statistics counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset; synchronous, active-low.
- stall_i  in  1  load-use hazard. Hold PC and IF/ID this cycle.
- jump_rst  in  1  taken branch/jump resolved in EX. Redirect and flush.
- jump_pc_i  in  32  redirect target, word address.
- halt_i  in  1  decoder reports a halt in IF/ID (qualified internally by valid_o).
- go_i  in  1  resume pulse from halted state.
- imem_addr_o  out  32  current PC. Instruction memory is combinational.
- imem_data_i  in  32  instruction at imem_addr_o, same cycle.
- IR_o  out  32  IF/ID instruction.
- PC_o  out  32  IF/ID PC+1 of that instruction.
- valid_o  out  1  IF/ID holds a real instruction.
- halted_o  out  1  FSM in HALT.
- cycle_cnt_o  out  CNT_W  cycles spent in RUN.
- instr_cnt_o  out  CNT_W  instructions passed from IF/ID to ID/EX.
- jump_cnt_o  out  CNT_W  redirects taken.
- stall_cnt_o  out  CNT_W  stall cycles.

Behaviour:
- Reset (rst==0 at posedge) values:
  - PC=RESET_PC, IR_o=NOP, PC_o=0, valid_o=0.
  - State RUN, halted_o=0, all counters 0.
  - Reset overrides everything, including mid-halt and mid-stall.
- imem_addr_o = PC register, combinationally.
- Latency: word fetched at PC appears on IR_o one cycle later, with PC_o=PC+1. 32-bit wrap on PC+1.
- FSM has two states, RUN and HALT. Per-cycle priority in RUN (first match wins):
  1. jump_rst: PC<=jump_pc_i; IR_o<=NOP, PC_o<=0, valid_o<=0. Any simultaneous stall_i or halt_i is ignored (that instruction is wrong-path).
  2. halt_i & valid_o & !stall_i: enter HALT. PC held (points after halt); IR_o<=NOP, valid_o<=0.
  3. stall_i: PC, IR_o, PC_o, valid_o all hold. A halt under stall is acted on once the stall drops.
  4. Normal: PC<=PC+1; IR_o<=imem_data_i, PC_o<=PC+1, valid_o<=1.
- In HALT:
  - PC frozen; IR_o=NOP, valid_o=0.
  - stall_i and halt_i are ignored.
  - go_i: return to RUN; fetch resumes at the frozen PC the following cycle.
  - jump_rst: defensive only. Apply redirect exactly as in RUN and return to RUN. jump_rst has priority over go_i.
- Counters, all wrapping modulo 2^CNT_W:
  - cycle_cnt: +1 each cycle in RUN, including the cycle halt is taken.
  - instr_cnt: +1 when in RUN & valid_o & !stall_i & !jump_rst.
  - jump_cnt: +1 per cycle with jump_rst (either state).
  - stall_cnt: +1 per RUN cycle with stall_i & !jump_rst.
- go_i held high in RUN has no effect.

Decomposition:
- Shared pipeline package holds:
  - NOP encoding and RESET_PC;
  - FSM state encoding (RUN=1'b0, HALT=1'b1);
  - the PC width constant (32) used also by id_ex and the NPC logic.
- One natural sub-module: stat_counter, a CNT_W-bit wrapping counter with synchronous active-low clear and an enable. Instantiated four times.
- The PC/IF-ID/FSM logic stays in fetch_if_id.

Test Plan:
- Memory model imem_data_i = 32'hA000_0000 | addr.
- Reset: hold rst=0 for 2 cycles, release.
  - 1st posedge: IR_o=32'hA000_0000, PC_o=1, valid_o=1, imem_addr_o=1.
  - Before that edge: IR_o=NOP, valid_o=0, counters 0.
- Stall: stall_i=1 for 2 cycles when imem_addr_o=5.
  - imem_addr_o stays 5; IR_o=32'hA000_0004, PC_o=5 held.
  - stall_cnt +2, instr_cnt unchanged.
  - Then IR_o=32'hA000_0005.
- Redirect: jump_rst=1, jump_pc_i=32'h20 together with stall_i=1.
  - Next cycle: imem_addr_o=32'h20, IR_o=NOP, valid_o=0, jump_cnt+1, stall_cnt unchanged.
  - Cycle after: IR_o=32'hA000_0020, PC_o=32'h21.
- Halt: halt_i=1 with valid_o=1 at imem_addr_o=9.
  - halted_o=1 next cycle; imem_addr_o stays 9; IR_o=NOP; cycle_cnt frozen for 10 cycles.
  - go_i pulse: RUN; next IR_o=32'hA000_0009.
- Reset mid-halt: in HALT, drive rst=0 for 1 cycle.
  - halted_o=0, imem_addr_o=RESET_PC, all counters 0.
- Wrap: CNT_W=4, run 17 RUN cycles with no stall or jump from reset.
  - cycle_cnt_o=1.
  - PC=32'hFFFF_FFFF via jump then normal fetch: PC_o=0.
